// File: rtl/cu_pkg.sv
// cu_pkg
// Shared definitions for the Mini SRC hardwired control unit:
//   - opcode values (IR[31:27])
//   - sequencer state encoding
//   - bit positions of every signal in the ctrl bundle
//   - opcode classification and last-step helpers used by the sequencer
package cu_pkg;

    localparam int OPCODE_W = 5;
    localparam int CTRL_W   = 32;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    // Sequencer states
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    // Bit positions within the ctrl bundle
    localparam int CTRL_PCOUT      = 0;
    localparam int CTRL_PCIN       = 1;
    localparam int CTRL_INCPC      = 2;
    localparam int CTRL_MARIN      = 3;
    localparam int CTRL_MDRIN      = 4;
    localparam int CTRL_MDROUT     = 5;
    localparam int CTRL_READ       = 6;
    localparam int CTRL_WRITE      = 7;
    localparam int CTRL_IRIN       = 8;
    localparam int CTRL_YIN        = 9;
    localparam int CTRL_ZLOWIN     = 10;
    localparam int CTRL_ZHIGHIN    = 11;
    localparam int CTRL_ZLOWOUT    = 12;
    localparam int CTRL_ZHIGHOUT   = 13;
    localparam int CTRL_GRA        = 14;
    localparam int CTRL_GRB        = 15;
    localparam int CTRL_GRC        = 16;
    localparam int CTRL_RIN        = 17;
    localparam int CTRL_ROUT       = 18;
    localparam int CTRL_BAOUT      = 19;
    localparam int CTRL_COUT       = 20;
    localparam int CTRL_LOIN       = 21;
    localparam int CTRL_HIIN       = 22;
    localparam int CTRL_LOOUT      = 23;
    localparam int CTRL_HIOUT      = 24;
    localparam int CTRL_CONIN      = 25;
    localparam int CTRL_R8IN       = 26;
    localparam int CTRL_INPORTOUT  = 27;
    localparam int CTRL_OUTPORTIN  = 28;

    // Instruction classes: opcodes that share an execute sequence
    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    // One-hot mask for a single ctrl bit
    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        logic [CTRL_W-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Undefined opcodes (11100-11111) fall into the nop class
    function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
        op_class_t c;
        if (op == OP_LD)                          c = C_LD;
        else if (op == OP_LDI)                    c = C_LDI;
        else if (op == OP_ST)                     c = C_ST;
        else if (op >= OP_ADD && op <= OP_ROL)    c = C_ALU;
        else if (op >= OP_ADDI && op <= OP_ORI)   c = C_IMM;
        else if (op == OP_MUL || op == OP_DIV)    c = C_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)    c = C_NEGNOT;
        else if (op == OP_BR)                     c = C_BR;
        else if (op == OP_JR)                     c = C_JR;
        else if (op == OP_JAL)                    c = C_JAL;
        else if (op == OP_IN)                     c = C_IN;
        else if (op == OP_OUT)                    c = C_OUT;
        else if (op == OP_MFHI)                   c = C_MFHI;
        else if (op == OP_MFLO)                   c = C_MFLO;
        else if (op == OP_HALT)                   c = C_HALT;
        else                                      c = C_NOP;
        return c;
    endfunction

    // Final execute step of each class; the edge leaving it is an
    // instruction boundary
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        case (c)
            C_LD, C_ST:             s = S_T7;
            C_MULDIV, C_BR:         s = S_T6;
            C_LDI, C_ALU, C_IMM:    s = S_T5;
            C_NEGNOT, C_JAL:        s = S_T4;
            default:                s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit
// Hardwired Moore sequencer for the Mini SRC datapath. Steps through
// fetch (T0-T2) and the opcode-specific execute steps (T3-T7), driving
// every register enable, tristate output and memory strobe.
//
// Ports:
//   clock   in   rising-edge system clock
//   clear   in   asynchronous active-high reset
//   ir      in   instruction register from datapath (opcode = ir[31:27])
//   con_ff  in   branch condition flip-flop from datapath
//   stop    in   external stop request, honoured at instruction boundaries
//   ctrl    out  control bundle, bit map in cu_pkg
//   alu_op  out  ALU operation select
//   run     out  high while executing (not in RESET/HALTED)
//   state   out  current step, cu_pkg encoding (debug)
module control_unit
    import cu_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int CTRLW = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       ir,
    input  logic              con_ff,
    input  logic              stop,
    output logic [CTRLW-1:0]  ctrl,
    output logic [OPW-1:0]    alu_op,
    output logic              run,
    output logic [3:0]        state
);

    state_t                 state_reg;
    state_t                 state_next;
    logic                   halt_flag_reg;
    logic                   halt_flag_next;

    logic [OPCODE_W-1:0]    opcode;
    op_class_t              op_class;
    logic [CTRL_W-1:0]      ctrl_word;
    logic [OPCODE_W-1:0]    alu_word;

    // Only the opcode field matters to the sequencer
    logic                   unused_ir_bits;
    assign unused_ir_bits = ^ir[31-OPCODE_W:0];

    assign opcode   = ir[31 -: OPCODE_W];
    assign op_class = classify(opcode);

    // ------------------------------------------------------------------
    // State register. halt_flag_reg distinguishes a halt-instruction stop
    // (sticky until clear) from an external stop (resumes on stop=0).
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg     <= S_RESET;
            halt_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            halt_flag_reg <= halt_flag_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        halt_flag_next = halt_flag_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_reg == last_step(op_class)) begin
                    if (op_class == C_HALT) begin
                        state_next     = S_HALTED;
                        halt_flag_next = 1'b1;
                    end else if (stop) begin
                        state_next     = S_HALTED;
                    end else begin
                        state_next     = S_T0;
                    end
                end else begin
                    state_next = state_t'(state_reg + 4'd1);
                end
            end
            S_HALTED: begin
                if (!halt_flag_reg && !stop) begin
                    state_next = S_T0;
                end
            end
            default: state_next = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from {state, opcode class}. Only the state register,
    // the stable ir and the already-latched con_ff feed this, so the
    // outputs settle once per cycle well before the datapath samples them.
    // RESET and HALTED leave everything at the defaults.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_word = '0;
        alu_word  = OP_ADD;
        case (state_reg)
            S_T0: ctrl_word = cbit(CTRL_PCOUT) | cbit(CTRL_MARIN);
            S_T1: ctrl_word = cbit(CTRL_READ) | cbit(CTRL_MDRIN) | cbit(CTRL_INCPC);
            S_T2: ctrl_word = cbit(CTRL_MDROUT) | cbit(CTRL_IRIN);

            S_T3: begin
                case (op_class)
                    C_LD, C_LDI, C_ST:
                        ctrl_word = cbit(CTRL_GRB) | cbit(CTRL_BAOUT) | cbit(CTRL_YIN);
                    C_ALU, C_IMM:
                        ctrl_word = cbit(CTRL_GRB) | cbit(CTRL_ROUT) | cbit(CTRL_YIN);
                    C_MULDIV:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_YIN);
                    C_NEGNOT: begin
                        // Unary ops go straight to Z with no Y operand
                        ctrl_word = cbit(CTRL_GRB) | cbit(CTRL_ROUT) | cbit(CTRL_ZLOWIN);
                        alu_word  = opcode;
                    end
                    C_BR:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_CONIN);
                    C_JR:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_PCIN);
                    C_JAL:
                        ctrl_word = cbit(CTRL_PCOUT) | cbit(CTRL_R8IN);
                    C_IN:
                        ctrl_word = cbit(CTRL_INPORTOUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    C_OUT:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_OUTPORTIN);
                    C_MFHI:
                        ctrl_word = cbit(CTRL_HIOUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    C_MFLO:
                        ctrl_word = cbit(CTRL_LOOUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    default: ctrl_word = '0;   // nop, undefined, halt
                endcase
            end

            S_T4: begin
                case (op_class)
                    C_LD, C_LDI, C_ST:
                        ctrl_word = cbit(CTRL_COUT) | cbit(CTRL_ZLOWIN);
                    C_ALU: begin
                        ctrl_word = cbit(CTRL_GRC) | cbit(CTRL_ROUT) | cbit(CTRL_ZLOWIN);
                        alu_word  = opcode;
                    end
                    C_IMM: begin
                        ctrl_word = cbit(CTRL_COUT) | cbit(CTRL_ZLOWIN);
                        alu_word  = opcode;
                    end
                    C_MULDIV: begin
                        ctrl_word = cbit(CTRL_GRB) | cbit(CTRL_ROUT) |
                                    cbit(CTRL_ZLOWIN) | cbit(CTRL_ZHIGHIN);
                        alu_word  = opcode;
                    end
                    C_NEGNOT:
                        ctrl_word = cbit(CTRL_ZLOWOUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    C_BR:
                        ctrl_word = cbit(CTRL_PCOUT) | cbit(CTRL_YIN);
                    C_JAL:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_PCIN);
                    default: ctrl_word = '0;
                endcase
            end

            S_T5: begin
                case (op_class)
                    C_LD, C_ST:
                        ctrl_word = cbit(CTRL_ZLOWOUT) | cbit(CTRL_MARIN);
                    C_LDI, C_ALU, C_IMM:
                        ctrl_word = cbit(CTRL_ZLOWOUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    C_MULDIV:
                        ctrl_word = cbit(CTRL_ZLOWOUT) | cbit(CTRL_LOIN);
                    C_BR:
                        ctrl_word = cbit(CTRL_COUT) | cbit(CTRL_ZLOWIN);
                    default: ctrl_word = '0;
                endcase
            end

            S_T6: begin
                case (op_class)
                    C_LD:
                        ctrl_word = cbit(CTRL_READ) | cbit(CTRL_MDRIN);
                    C_ST:
                        ctrl_word = cbit(CTRL_GRA) | cbit(CTRL_ROUT) | cbit(CTRL_MDRIN);
                    C_MULDIV:
                        ctrl_word = cbit(CTRL_ZHIGHOUT) | cbit(CTRL_HIIN);
                    C_BR: begin
                        // Target is always driven; PC only loads if taken
                        ctrl_word = cbit(CTRL_ZLOWOUT);
                        if (con_ff) begin
                            ctrl_word = ctrl_word | cbit(CTRL_PCIN);
                        end
                    end
                    default: ctrl_word = '0;
                endcase
            end

            S_T7: begin
                case (op_class)
                    C_LD:
                        ctrl_word = cbit(CTRL_MDROUT) | cbit(CTRL_GRA) | cbit(CTRL_RIN);
                    C_ST:
                        ctrl_word = cbit(CTRL_WRITE);
                    default: ctrl_word = '0;
                endcase
            end

            default: begin
                ctrl_word = '0;
                alu_word  = OP_ADD;
            end
        endcase
    end

    assign ctrl   = CTRLW'(ctrl_word);
    assign alu_op = OPW'(alu_word);
    assign run    = (state_reg != S_RESET) && (state_reg != S_HALTED);
    assign state  = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit. Each instruction's expected
// per-cycle outputs are pushed to a scoreboard queue when the instruction
// is issued, then popped and compared one step per falling clock edge.
module tb_control_unit;
    import cu_pkg::*;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [31:0] ctrl;
    logic [4:0]  alu_op;
    logic        run;
    logic [3:0]  state;

    control_unit #(.OPW(5), .CTRLW(32)) dut (
        .clock  (clock),
        .clear  (clear),
        .ir     (ir),
        .con_ff (con_ff),
        .stop   (stop),
        .ctrl   (ctrl),
        .alu_op (alu_op),
        .run    (run),
        .state  (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] ctl;
        logic [4:0]  alu;
        logic        rn;
    } step_t;

    step_t  sb[$];
    int     checks = 0;
    int     errors = 0;
    string  cur_name = "reset";

    logic   mon_write = 1'b0;
    logic   write_seen = 1'b0;

    always @(negedge clock) begin
        if (mon_write && ctrl[CTRL_WRITE]) write_seen <= 1'b1;
    end

    function automatic logic [31:0] b(input int idx);
        logic [31:0] m;
        m = 32'd0;
        m[idx] = 1'b1;
        return m;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got %08h expected %08h", cur_name, tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [31:0] ctl, input logic [4:0] alu);
        step_t e;
        e.st  = st;
        e.ctl = ctl;
        e.alu = alu;
        e.rn  = (st != S_RESET) && (st != S_HALTED);
        sb.push_back(e);
    endtask

    task automatic push_fetch();
        push(S_T0, b(CTRL_PCOUT) | b(CTRL_MARIN), OP_ADD);
        push(S_T1, b(CTRL_READ) | b(CTRL_MDRIN) | b(CTRL_INCPC), OP_ADD);
        push(S_T2, b(CTRL_MDROUT) | b(CTRL_IRIN), OP_ADD);
    endtask

    // Wait for the edge that enters T0, then present the new instruction
    task automatic begin_instr(input string name, input logic [4:0] op, input logic c);
        @(posedge clock);
        #1;
        cur_name = name;
        ir       = {op, 27'h0123456};
        con_ff   = c;
        push_fetch();
    endtask

    task automatic drain();
        step_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clock);
            check_val($sformatf("state%0d", e.st), 32'(state), 32'(e.st));
            check_val($sformatf("ctrl%0d",  e.st), ctrl, e.ctl);
            check_val($sformatf("alu%0d",   e.st), 32'(alu_op), 32'(e.alu));
            check_val($sformatf("run%0d",   e.st), 32'(run), 32'(e.rn));
            $display("%s step %0d ctrl=%08h alu=%02h run=%0b", cur_name, state, ctrl, alu_op, run);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_state", 32'(state), 32'(S_RESET));
        check_val("rst_ctrl",  ctrl, 32'd0);
        check_val("rst_alu",   32'(alu_op), 32'(OP_ADD));
        check_val("rst_run",   32'(run), 32'd0);
    endtask

    // Single-step instructions with a fixed T3 pattern
    task automatic one_step(input string name, input logic [4:0] op, input logic [31:0] t3);
        begin_instr(name, op, 1'b0);
        push(S_T3, t3, OP_ADD);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear  = 1'b1;
        ir     = 32'd0;
        con_ff = 1'b0;
        stop   = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        check_reset_outputs();
        clear = 1'b0;

        // ld R1,0x75(R0)
        begin_instr("ld", OP_LD, 1'b0);
        ir = 32'h00800075;
        push(S_T3, b(CTRL_GRB) | b(CTRL_BAOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_MARIN), OP_ADD);
        push(S_T6, b(CTRL_READ) | b(CTRL_MDRIN), OP_ADD);
        push(S_T7, b(CTRL_MDROUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("ldi", OP_LDI, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_BAOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("st", OP_ST, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_BAOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_MARIN), OP_ADD);
        push(S_T6, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_MDRIN), OP_ADD);
        push(S_T7, b(CTRL_WRITE), OP_ADD);
        drain();

        begin_instr("sub", OP_SUB, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_GRC) | b(CTRL_ROUT) | b(CTRL_ZLOWIN), 5'b00100);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("rol", OP_ROL, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_GRC) | b(CTRL_ROUT) | b(CTRL_ZLOWIN), 5'b01011);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("andi", OP_ANDI, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_COUT) | b(CTRL_ZLOWIN), 5'b01101);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("mul", OP_MUL, 1'b0);
        push(S_T3, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_ZLOWIN) | b(CTRL_ZHIGHIN), 5'b01111);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_LOIN), OP_ADD);
        push(S_T6, b(CTRL_ZHIGHOUT) | b(CTRL_HIIN), OP_ADD);
        drain();

        begin_instr("div", OP_DIV, 1'b0);
        push(S_T3, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_ZLOWIN) | b(CTRL_ZHIGHIN), 5'b10000);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_LOIN), OP_ADD);
        push(S_T6, b(CTRL_ZHIGHOUT) | b(CTRL_HIIN), OP_ADD);
        drain();

        begin_instr("neg", OP_NEG, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_ZLOWIN), 5'b10001);
        push(S_T4, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("not", OP_NOT, 1'b0);
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_ZLOWIN), 5'b10010);
        push(S_T4, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();

        begin_instr("br_taken", OP_BR, 1'b1);
        push(S_T3, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_CONIN), OP_ADD);
        push(S_T4, b(CTRL_PCOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T5, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T6, b(CTRL_ZLOWOUT) | b(CTRL_PCIN), OP_ADD);
        drain();

        begin_instr("br_not", OP_BR, 1'b0);
        push(S_T3, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_CONIN), OP_ADD);
        push(S_T4, b(CTRL_PCOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T5, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T6, b(CTRL_ZLOWOUT), OP_ADD);
        drain();

        begin_instr("jal", OP_JAL, 1'b0);
        push(S_T3, b(CTRL_PCOUT) | b(CTRL_R8IN), OP_ADD);
        push(S_T4, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_PCIN), OP_ADD);
        drain();

        one_step("jr",   OP_JR,   b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_PCIN));
        one_step("in",   OP_IN,   b(CTRL_INPORTOUT) | b(CTRL_GRA) | b(CTRL_RIN));
        one_step("out",  OP_OUT,  b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_OUTPORTIN));
        one_step("mfhi", OP_MFHI, b(CTRL_HIOUT) | b(CTRL_GRA) | b(CTRL_RIN));
        one_step("mflo", OP_MFLO, b(CTRL_LOOUT) | b(CTRL_GRA) | b(CTRL_RIN));
        one_step("nop",  OP_NOP,  32'd0);
        one_step("undef", 5'b11101, 32'd0);

        // stop raised early in an add: instruction completes, then HALTED
        begin_instr("add_stop", OP_ADD, 1'b0);
        stop = 1'b1;
        push(S_T3, b(CTRL_GRB) | b(CTRL_ROUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_GRC) | b(CTRL_ROUT) | b(CTRL_ZLOWIN), 5'b00011);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        drain();
        stop = 1'b0;
        one_step("resume_jr", OP_JR, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_PCIN));

        // clear during st T6: Write must never appear
        begin_instr("st_abort", OP_ST, 1'b0);
        mon_write = 1'b1;
        push(S_T3, b(CTRL_GRB) | b(CTRL_BAOUT) | b(CTRL_YIN), OP_ADD);
        push(S_T4, b(CTRL_COUT) | b(CTRL_ZLOWIN), OP_ADD);
        push(S_T5, b(CTRL_ZLOWOUT) | b(CTRL_MARIN), OP_ADD);
        push(S_T6, b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_MDRIN), OP_ADD);
        drain();
        #1;
        clear = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clock);
        #1;
        check_reset_outputs();
        @(negedge clock);
        check_reset_outputs();
        clear = 1'b0;
        begin_instr("restart_mflo", OP_MFLO, 1'b0);
        push(S_T3, b(CTRL_LOOUT) | b(CTRL_GRA) | b(CTRL_RIN), OP_ADD);
        drain();
        mon_write = 1'b0;
        check_val("write_seen", 32'(write_seen), 32'd0);

        // halt instruction: stays HALTED with stop low until clear
        begin_instr("halt", OP_HALT, 1'b0);
        push(S_T3, 32'd0, OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        push(S_HALTED, 32'd0, OP_ADD);
        drain();
        clear = 1'b1;
        #1;
        cur_name = "halt_clear";
        check_reset_outputs();
        @(negedge clock);
        clear = 1'b0;
        one_step("after_halt_nop", OP_NOP, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
